math_peak_find_17: RTL and testbench
====================================

Name: math_peak_find_17

Overview:
- Windowed peak search on the 17-bit unsigned magnitude stream from the complex-abs stage.
- Scans a window of WIN_LEN valid samples and reports the largest magnitude, its in-window index, and whether it reached a threshold.
- Sits directly downstream of the magnitude computation and feeds correlation/detection control logic.

Parameters:
- DW, 17, magnitude width (unsigned).
- AW, 10, index/counter width.
- WIN_LEN, 1024, samples per window. Legal range is 2..2^AW; values outside this range are a configuration error.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- ena  input  1  clock enable. When low, all registers hold.
- start  input  1  arms a new window search. Accepted only in IDLE.
- din_valid  input  1  din carries a sample this cycle.
- din  input  DW  unsigned magnitude sample.
- thresh  input  DW  detection threshold. Captured at start.
- busy  output  1  high while in SEARCH.
- peak_valid  output  1  one-cycle result strobe.
- peak_mag  output  DW  largest magnitude in the window.
- peak_idx  output  AW  index (0..WIN_LEN-1) of the first occurrence of peak_mag.
- peak_hit  output  1  peak_mag >= captured thresh.
- overrun  output  1  one-cycle pulse: start seen while busy.

Behaviour:
- Reset (rst=0 at a clk edge, regardless of ena): state IDLE; busy, peak_valid, peak_mag, peak_idx, peak_hit, overrun, sample counter, running max/index and thresh register all 0.
- Reset mid-window aborts the search with no peak_valid.
- Every register below updates only on edges with ena=1 and rst=1. With ena=0 all state and outputs hold, including a pending peak_valid or overrun; downstream qualifies with ena.
- States: IDLE, SEARCH.
- IDLE:
  - start=1 -> SEARCH, thresh captured, busy=1 from the next cycle.
  - If din_valid=1 on the start cycle, that sample is accepted as index 0.
  - din_valid without start is ignored.
- SEARCH, each accepted sample (din_valid=1):
  - Index 0 loads the running max unconditionally.
  - Later samples replace the max only if din > max (strict), so ties keep the earliest index.
  - Counter increments on each accepted sample; cycles with din_valid=0 do not advance it. There is no timeout.
- Window end: on the edge accepting index WIN_LEN-1:
  - peak_mag/peak_idx are loaded with the final max/index, including that last sample.
  - peak_hit = (final max >= thresh).
  - peak_valid=1 for exactly the next cycle; state returns to IDLE; busy=0 from the next cycle.
- Latency: peak_valid is high in the cycle immediately after the last sample is presented.
- Results persist: peak_mag/idx/hit hold until the next window completes. They do not change during a search.
- start in SEARCH, including on the final-sample cycle: ignored for search purposes; overrun pulses one cycle.
- start in the first IDLE cycle after completion, i.e. concurrent with peak_valid: accepted normally, back-to-back windows with zero gap.
- Comparisons are unsigned. din=2^DW-1 is a legal peak. thresh=0 makes peak_hit always 1.
- Counter wraps to 0 at window end. It never reaches WIN_LEN.

Test Plan:
- WIN_LEN=8; start with din_valid; samples 5,9,3,9,1,0,2,7 back-to-back -> peak_valid one cycle after sample 7; peak_mag=9, peak_idx=1 (tie keeps first). With thresh=9, peak_hit=1.
- WIN_LEN=8; same data with din_valid gaps of 0–3 cycles; thresh=10 -> identical mag/idx, peak_hit=0, busy high throughout, peak_valid exactly once.
- Maximum at last sample: 0×7 then 0x1FFFF -> peak_mag=0x1FFFF, peak_idx=7. Then repeat with all-zero samples -> peak_mag=0, peak_idx=0.
- start pulsed mid-window and on the final-sample cycle -> overrun pulses each time, result unaffected. start concurrent with peak_valid -> second window begins and completes with its own correct result.
- ena toggled low for random cycles, including the peak_valid cycle -> all outputs freeze. peak_valid stays high until the next ena=1 edge, then drops. Results match the ena-always-high run.
- rst=0 asserted after 4 samples -> all outputs 0 next cycle, no peak_valid. A new start yields a correct fresh window.

Source files
------------

// File: rtl/math_peak_find_17.sv
// Windowed peak search over an unsigned magnitude stream.
// Reports largest sample, first index of it, and threshold hit.
module math_peak_find_17 #(
    parameter int DW      = 17,
    parameter int AW      = 10,
    parameter int WIN_LEN = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] thresh,
    output logic          busy,
    output logic          peak_valid,
    output logic [DW-1:0] peak_mag,
    output logic [AW-1:0] peak_idx,
    output logic          peak_hit,
    output logic          overrun
);

    if (WIN_LEN < 2 || WIN_LEN > (1 << AW)) begin : g_bad_cfg
        $error("math_peak_find_17: WIN_LEN out of range 2..2^AW");
    end

    localparam logic [AW-1:0] LAST = AW'(WIN_LEN - 1);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] max_idx;
    logic [DW-1:0] max_mag;
    logic [DW-1:0] thr;

    logic          first;
    logic          last;
    logic [DW-1:0] next_mag;
    logic [AW-1:0] next_idx;

    // Running max including the current sample; index 0 loads unconditionally,
    // later samples win only on strictly greater so ties keep the earliest.
    always_comb begin
        first    = (cnt == '0);
        last     = (cnt == LAST);
        next_mag = max_mag;
        next_idx = max_idx;
        if (first || (din > max_mag)) begin
            next_mag = din;
            next_idx = cnt;
        end
    end

    // Control FSM, running max and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_idx   <= '0;
            peak_hit   <= 1'b0;
            overrun    <= 1'b0;
            cnt        <= '0;
            max_mag    <= '0;
            max_idx    <= '0;
            thr        <= '0;
        end else if (ena) begin
            peak_valid <= 1'b0;
            overrun    <= (state == SEARCH) && start;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SEARCH;
                        busy  <= 1'b1;
                        thr   <= thresh;
                        if (din_valid) begin
                            max_mag <= din;
                            max_idx <= '0;
                            cnt     <= AW'(1);
                        end
                    end
                end
                SEARCH: begin
                    if (din_valid) begin
                        max_mag <= next_mag;
                        max_idx <= next_idx;
                        if (last) begin
                            peak_mag   <= next_mag;
                            peak_idx   <= next_idx;
                            peak_hit   <= (next_mag >= thr);
                            peak_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_math_peak_find_17.sv
// Directed bench for math_peak_find_17 with WIN_LEN=8.
// Expected results are queued at start and popped on peak_valid.
module tb_math_peak_find_17;

    localparam int DW = 17;
    localparam int AW = 10;
    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] thresh = '0;
    logic          busy;
    logic          peak_valid;
    logic [DW-1:0] peak_mag;
    logic [AW-1:0] peak_idx;
    logic          peak_hit;
    logic          overrun;
    logic [30:0]   outs;

    typedef struct packed {
        logic [DW-1:0] mag;
        logic [AW-1:0] idx;
        logic          hit;
    } res_t;

    res_t          sbq[$];
    res_t          prev = '0;
    int            checks = 0;
    int            errors = 0;
    int            npv = 0;
    bit            rand_ena = 1'b0;
    logic [DW-1:0] win[WL];

    math_peak_find_17 #(.DW(DW), .AW(AW), .WIN_LEN(WL)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .din_valid(din_valid), .din(din), .thresh(thresh),
        .busy(busy), .peak_valid(peak_valid), .peak_mag(peak_mag),
        .peak_idx(peak_idx), .peak_hit(peak_hit), .overrun(overrun)
    );

    assign outs = {busy, peak_valid, peak_mag, peak_idx, peak_hit, overrun};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [DW-1:0] t);
        res_t r;
        r.mag = win[0];
        r.idx = '0;
        for (int i = 1; i < WL; i++) begin
            if (win[i] > r.mag) begin
                r.mag = win[i];
                r.idx = AW'(i);
            end
        end
        r.hit = (r.mag >= t);
        return r;
    endfunction

    // Scoreboard: a strobe is consumed at the next edge with ena high.
    always @(negedge clk) begin
        if (rst && peak_valid && ena) begin
            res_t e;
            npv++;
            checks++;
            assert (sbq.size() != 0)
            else begin
                errors++;
                $error("FAIL pv_unexpected observed=%0h expected=none",
                       peak_mag);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("peak_mag", 32'(peak_mag), 32'(e.mag));
                chk("peak_idx", 32'(peak_idx), 32'(e.idx));
                chk("peak_hit", 32'(peak_hit), 32'(e.hit));
                prev = e;
            end
        end
    end

    // Hold inputs until an edge with ena=1 takes them; check freeze otherwise.
    task automatic drive(input bit st, input bit dv, input logic [DW-1:0] d);
        logic [30:0] snap;
        bit          en;
        start     = st;
        din_valid = dv;
        din       = d;
        do begin
            en   = rand_ena ? ($urandom_range(0, 2) != 0) : 1'b1;
            ena  = en;
            snap = outs;
            @(posedge clk);
            #1;
            if (!en) chk("freeze", 32'(outs), 32'(snap));
        end while (!en);
        start     = 1'b0;
        din_valid = 1'b0;
        ena       = 1'b1;
    endtask

    task automatic run_win(input logic [DW-1:0] thr, input int maxgap,
                           input int ov_a, input int ov_b);
        int ng;
        bit st;
        sbq.push_back(model(thr));
        thresh = thr;
        drive(1'b1, 1'b1, win[0]);
        thresh = ~thr;
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 1; i < WL; i++) begin
            ng = $urandom_range(0, maxgap);
            repeat (ng) begin
                drive(1'b0, 1'b0, 17'h15555);
                chk("busy_gap", 32'(busy), 32'd1);
            end
            if (i == 4) begin
                chk("persist_mag", 32'(peak_mag), 32'(prev.mag));
                chk("persist_idx", 32'(peak_idx), 32'(prev.idx));
                chk("persist_hit", 32'(peak_hit), 32'(prev.hit));
            end
            st = (i == ov_a) || (i == ov_b);
            drive(st, 1'b1, win[i]);
            chk("overrun", 32'(overrun), st ? 32'd1 : 32'd0);
        end
        chk("pv_end", 32'(peak_valid), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic set_win(input logic [8*DW-1:0] v);
        for (int i = 0; i < WL; i++) win[i] = v[(WL-1-i)*DW +: DW];
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);

        set_win({17'd5, 17'd9, 17'd3, 17'd9, 17'd1, 17'd0, 17'd2, 17'd7});
        run_win(17'd9, 0, -1, -1);
        drive(1'b0, 1'b0, '0);
        chk("pv_drop", 32'(peak_valid), 32'd0);

        run_win(17'd10, 3, -1, -1);
        drive(1'b0, 1'b0, '0);

        set_win({17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0,
                 17'h1FFFF});
        run_win(17'h1FFFF, 1, -1, -1);
        set_win('0);
        run_win(17'd0, 0, -1, -1);
        drive(1'b0, 1'b0, '0);

        set_win({17'd4, 17'd8, 17'd8, 17'd1, 17'd12, 17'd3, 17'd12, 17'd6});
        run_win(17'd12, 1, 3, 7);
        set_win({17'd20, 17'd21, 17'd99, 17'd5, 17'd99, 17'd0, 17'd3,
                 17'd98});
        run_win(17'd100, 0, -1, -1);
        drive(1'b0, 1'b0, '0);

        rand_ena = 1'b1;
        set_win({17'd5, 17'd9, 17'd3, 17'd9, 17'd1, 17'd0, 17'd2, 17'd7});
        run_win(17'd9, 2, -1, -1);
        drive(1'b0, 1'b0, '0);
        chk("pv_drop_ena", 32'(peak_valid), 32'd0);
        rand_ena = 1'b0;

        thresh = 17'd5;
        drive(1'b1, 1'b1, 17'd40);
        drive(1'b0, 1'b1, 17'd41);
        drive(1'b0, 1'b1, 17'd42);
        drive(1'b0, 1'b1, 17'd43);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid_reset", 32'(outs), 32'd0);
        prev = '0;
        repeat (2) drive(1'b0, 1'b1, 17'd44);
        chk("no_pv_after_rst", 32'(peak_valid), 32'd0);
        run_win(17'd9, 1, -1, -1);

        repeat (3) drive(1'b0, 1'b0, '0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("pv_count", 32'(npv), 32'd8);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
